// File: rtl/ahci_dma_wr_stuff_if.sv
// Data-path handshake bundle for the DMA write-side stuffer: 32-bit input stream
// with valid/ready, and 32-bit output DWORD with word mask and valid/read-enable.
interface ahci_dma_wr_stuff_if;
  logic [31:0] din;
  logic        din_vld;
  logic        din_rdy;
  logic [31:0] dout;
  logic [1:0]  dout_dm;
  logic        dout_vld;
  logic        dout_re;

  modport master (
    output din,
    output din_vld,
    output dout_re,
    input  din_rdy,
    input  dout,
    input  dout_dm,
    input  dout_vld
  );

  modport slave (
    input  din,
    input  din_vld,
    input  dout_re,
    output din_rdy,
    output dout,
    output dout_dm,
    output dout_vld
  );
endinterface

// File: rtl/ahci_dma_wr_stuff.sv
// Re-aligns a continuous 32-bit stream to a 16-bit word start offset inside the destination
// DWORD; each output DWORD carries a 2-bit word mask, the odd trailing word is emitted on flush.
module ahci_dma_wr_stuff #(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic                init_odd,
  input  logic                flush,
  ahci_dma_wr_stuff_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic [CNT_BITS-1:0] dout_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};

  state_t      state;
  state_t      state_nxt;
  logic        phase;
  logic        phase_nxt;
  logic [15:0] hr;
  logic [15:0] hr_nxt;
  logic        hr_full;
  logic        hr_full_nxt;
  logic        done_nxt;

  logic        slot_free;
  logic        accept;
  logic        load;
  logic [31:0] load_data;
  logic [1:0]  load_dm;

  logic [31:0] dout_r;
  logic [1:0]  dm_r;
  logic        vld_r;

  // Odd alignment: the new low word goes up, the held word (or zero) fills the low half.
  function automatic logic [33:0] odd_pack(input logic [31:0] d, input logic [15:0] h,
                                           input logic hf);
    odd_pack = {1'b1, hf, d[15:0], (hf ? h : 16'h0000)};
  endfunction

  assign slot_free    = ~vld_r | bus.dout_re;
  assign bus.din_rdy  = (state == RUN) & slot_free & ~init & ~flush;
  assign accept       = bus.din_vld & bus.din_rdy;
  assign bus.dout     = dout_r;
  assign bus.dout_dm  = dm_r;
  assign bus.dout_vld = vld_r;

  // Next-state, holding-register and output-load decode.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    hr_nxt      = hr;
    hr_full_nxt = hr_full;
    done_nxt    = 1'b0;
    load        = 1'b0;
    load_data   = 32'h0000_0000;
    load_dm     = 2'b00;

    if (init) begin
      // init overrides everything, including a pending flush.
      state_nxt   = RUN;
      phase_nxt   = init_odd;
      hr_full_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            done_nxt = 1'b1;
          end else begin
            done_nxt = 1'b0;
          end
        end
        RUN: begin
          if (flush) begin
            state_nxt = FLUSH;
          end else if (accept) begin
            load = 1'b1;
            if (phase) begin
              {load_dm, load_data} = odd_pack(bus.din, hr, hr_full);
              hr_nxt               = bus.din[31:16];
              hr_full_nxt          = 1'b1;
            end else begin
              load_data = bus.din;
              load_dm   = 2'b11;
            end
          end else begin
            state_nxt = RUN;
          end
        end
        FLUSH: begin
          if (slot_free) begin
            if (hr_full) begin
              load      = 1'b1;
              load_data = {16'h0000, hr};
              load_dm   = 2'b01;
            end else begin
              load      = 1'b0;
            end
            hr_full_nxt = 1'b0;
            phase_nxt   = 1'b0;
            state_nxt   = IDLE;
            done_nxt    = 1'b1;
          end else begin
            state_nxt = FLUSH;
          end
        end
        default: begin
          state_nxt   = IDLE;
          phase_nxt   = 1'b0;
          hr_full_nxt = 1'b0;
        end
      endcase
    end
  end

  // Control state, holding register and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= 1'b0;
      hr      <= 16'h0000;
      hr_full <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      hr      <= hr_nxt;
      hr_full <= hr_full_nxt;
      done    <= done_nxt;
      busy    <= (state_nxt != IDLE);
    end
  end

  // Output DWORD register; holds under back-pressure, a load only happens when the slot is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r <= 32'h0000_0000;
      dm_r   <= 2'b00;
      vld_r  <= 1'b0;
    end else if (load) begin
      dout_r <= load_data;
      dm_r   <= load_dm;
      vld_r  <= 1'b1;
    end else if (bus.dout_re) begin
      vld_r  <= 1'b0;
    end else begin
      vld_r  <= vld_r;
    end
  end

  // Consumed-DWORD counter, restarted by init.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_cnt <= CNT_ZERO;
    end else if (init) begin
      dout_cnt <= CNT_ZERO;
    end else if (vld_r & bus.dout_re) begin
      dout_cnt <= dout_cnt + CNT_ONE;
    end else begin
      dout_cnt <= dout_cnt;
    end
  end

endmodule

// File: tb/tb_ahci_dma_wr_stuff.sv
// Scoreboard bench for ahci_dma_wr_stuff: directed transfers push expected {dm,dout} words,
// a negedge monitor pops and compares every consumed output DWORD.
module tb_ahci_dma_wr_stuff;
  localparam int CNT_BITS = 4;

  logic                clk      = 1'b0;
  logic                rst      = 1'b1;
  logic                init     = 1'b0;
  logic                init_odd = 1'b0;
  logic                flush    = 1'b0;
  logic                busy;
  logic                done;
  logic [CNT_BITS-1:0] dout_cnt;

  ahci_dma_wr_stuff_if bus();

  ahci_dma_wr_stuff #(.CNT_BITS(CNT_BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .init_odd (init_odd),
    .flush    (flush),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .dout_cnt (dout_cnt)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int          done_seen   = 0;
  int          stall_viol  = 0;
  int          hold_viol   = 0;
  int          re_mode     = 0;  // 0: never read, 1: always read, 2: ~30% stall
  logic [33:0] sb[$];

  logic [31:0] bp_din [8] = '{32'hA000_B000, 32'hA001_B001, 32'hA002_B002, 32'hA003_B003,
                              32'hA004_B004, 32'hA005_B005, 32'hA006_B006, 32'hA007_B007};
  logic [33:0] bp_exp [9] = '{{2'b10, 32'hB000_0000}, {2'b11, 32'hB001_A000},
                              {2'b11, 32'hB002_A001}, {2'b11, 32'hB003_A002},
                              {2'b11, 32'hB004_A003}, {2'b11, 32'hB005_A004},
                              {2'b11, 32'hB006_A005}, {2'b11, 32'hB007_A006},
                              {2'b01, 32'h0000_A007}};

  initial begin
    bus.din     = 32'h0;
    bus.din_vld = 1'b0;
    bus.dout_re = 1'b0;
  end

  // Read-enable driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (re_mode)
        1:       bus.dout_re = 1'b1;
        2:       bus.dout_re = ($urandom_range(0, 9) >= 3);
        default: bus.dout_re = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pop/compare, done counting, stall and hold checks.
  initial begin
    logic [33:0] e;
    logic        prev_stall;
    logic [33:0] prev_out;
    prev_stall = 1'b0;
    prev_out   = 34'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (done) done_seen++;
        if (bus.dout_vld && bus.dout_re) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_out: got dm=%b dout=%h, nothing expected", bus.dout_dm, bus.dout);
          end else begin
            e = sb.pop_front();
            if ({bus.dout_dm, bus.dout} !== e) begin
              miscompares++;
              $display("FAIL dout: got dm=%b dout=%h, expected dm=%b dout=%h",
                       bus.dout_dm, bus.dout, e[33:32], e[31:0]);
            end
          end
        end
        if (bus.dout_vld && !bus.dout_re && bus.din_rdy) stall_viol++;
        if (prev_stall && ({bus.dout_dm, bus.dout} !== prev_out)) hold_viol++;
        prev_stall = bus.dout_vld && !bus.dout_re;
        prev_out   = {bus.dout_dm, bus.dout};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_init(input logic odd);
    init     = 1'b1;
    init_odd = odd;
    tick(1);
    init     = 1'b0;
    init_odd = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    bus.din     = d;
    bus.din_vld = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = bus.din_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    bus.din_vld = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: din %h not accepted in %0d cycles", d, n);
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_seen < target && n < 300) begin
      tick(1);
      n++;
    end
    chk("done_count", done_seen, target);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int d;

    // Reset state
    tick(2);
    chk("rst_dout_vld", bus.dout_vld, 0);
    chk("rst_dout", bus.dout, 32'h0);
    chk("rst_dout_dm", bus.dout_dm, 0);
    chk("rst_din_rdy", bus.din_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", dout_cnt, 0);
    rst = 1'b0;
    re_mode = 1;
    tick(2);

    // 1: even alignment
    do_init(1'b0);
    chk("t1_busy", busy, 1);
    sb.push_back({2'b11, 32'h1111_2222});
    send(32'h1111_2222);
    sb.push_back({2'b11, 32'h3333_4444});
    send(32'h3333_4444);
    d = done_seen;
    do_flush();
    wait_done(d + 1);
    wait_empty();
    tick(2);
    chk("t1_cnt", dout_cnt, 2);
    chk("t1_busy_end", busy, 0);

    // 2: odd alignment with partial on flush
    do_init(1'b1);
    sb.push_back({2'b10, 32'hBBBB_0000});
    send(32'hAAAA_BBBB);
    sb.push_back({2'b11, 32'hDDDD_AAAA});
    send(32'hCCCC_DDDD);
    sb.push_back({2'b01, 32'h0000_CCCC});
    d = done_seen;
    do_flush();
    wait_done(d + 1);
    wait_empty();
    tick(2);
    chk("t2_cnt", dout_cnt, 3);

    // 3: random back-pressure, odd mode
    re_mode = 2;
    do_init(1'b1);
    for (int i = 0; i < 8; i++) begin
      sb.push_back(bp_exp[i]);
      send(bp_din[i]);
    end
    sb.push_back(bp_exp[8]);
    d = done_seen;
    do_flush();
    wait_done(d + 1);
    wait_empty();
    re_mode = 1;
    tick(3);
    chk("t3_cnt", dout_cnt, 9);
    chk("t3_stall_rdy", stall_viol, 0);
    chk("t3_hold", hold_viol, 0);

    // 4a: flush in IDLE -> done only
    d = done_seen;
    do_flush();
    tick(3);
    chk("t4a_done", done_seen, d + 1);
    chk("t4a_busy", busy, 0);

    // 4b: init and flush together -> RUN, no done
    d = done_seen;
    init  = 1'b1;
    flush = 1'b1;
    tick(1);
    init  = 1'b0;
    flush = 1'b0;
    tick(3);
    chk("t4b_busy", busy, 1);
    chk("t4b_no_done", done_seen, d);
    do_flush();
    wait_done(d + 1);

    // 4c: init while flush is stalled -> no partial, no done
    re_mode = 0;
    tick(2);
    do_init(1'b1);
    sb.push_back({2'b10, 32'h1111_0000});
    send(32'hAAAA_1111);
    d = done_seen;
    do_flush();
    tick(3);
    chk("t4c_busy_stalled", busy, 1);
    chk("t4c_vld_stalled", bus.dout_vld, 1);
    do_init(1'b0);
    re_mode = 1;
    wait_empty();
    sb.push_back({2'b11, 32'h1234_5678});
    send(32'h1234_5678);
    do_flush();
    wait_done(d + 1);
    wait_empty();
    tick(3);
    chk("t4c_single_done", done_seen, d + 1);
    chk("t4c_hold", hold_viol, 0);

    // 5: async reset mid-RUN with held word and stalled output
    re_mode = 0;
    tick(2);
    do_init(1'b1);
    sb.push_back({2'b10, 32'h8888_0000});
    send(32'h7777_8888);
    tick(1);
    chk("t5_vld_before", bus.dout_vld, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_dout_vld", bus.dout_vld, 0);
    chk("t5_dout", bus.dout, 32'h0);
    chk("t5_dm", bus.dout_dm, 0);
    chk("t5_din_rdy", bus.din_rdy, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cnt", dout_cnt, 0);
    sb.delete();
    tick(2);
    rst = 1'b0;
    re_mode = 1;
    tick(2);
    do_init(1'b1);
    sb.push_back({2'b10, 32'h6666_0000});
    send(32'h5555_6666);
    sb.push_back({2'b01, 32'h0000_5555});
    d = done_seen;
    do_flush();
    wait_done(d + 1);
    wait_empty();
    tick(2);
    chk("t5_cnt_after", dout_cnt, 2);

    // 6: counter wrap with 4-bit counter
    do_init(1'b0);
    for (int i = 0; i < 17; i++) begin
      sb.push_back({2'b11, 32'h0101_0101 * (i + 1)});
      send(32'h0101_0101 * (i + 1));
    end
    d = done_seen;
    do_flush();
    wait_done(d + 1);
    wait_empty();
    tick(2);
    chk("t6_cnt_wrap", dout_cnt, 1);
    do_init(1'b0);
    chk("t6_cnt_clear", dout_cnt, 0);
    do_flush();
    tick(3);
    chk("t6_stall_rdy", stall_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
